// File: rtl/serial_slice_adder_if.sv
// Operand/result handshake bundle for serial_slice_adder.
// Optional overflow/zero flag signals exist only when SERIAL_SLICE_ADDER_FLAGS_EN is defined.
interface serial_slice_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             subtract;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
`ifdef SERIAL_SLICE_ADDER_FLAGS_EN
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, carry_in, subtract, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, carry_in, subtract, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, zero
  );
`else
  modport master (
    output in_valid, a, b, carry_in, subtract, out_ready,
    input  in_ready, out_valid, sum, carry_out
  );

  modport slave (
    input  in_valid, a, b, carry_in, subtract, out_ready,
    output in_ready, out_valid, sum, carry_out
  );
`endif
endinterface

// File: rtl/serial_slice_adder.sv
// Bit-serial-by-slice adder/subtractor: SLICE bits per clock, LSB slice first, carry kept in a register.
// Optional macro SERIAL_SLICE_ADDER_FLAGS_EN adds registered overflow and zero flags.
module serial_slice_adder #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic clk,
  input  logic reset,
  serial_slice_adder_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_upd;
  logic             carry_q;
  logic             carry_out_q;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] s_sl;
  logic             c_sl;

`ifdef SERIAL_SLICE_ADDER_FLAGS_EN
  logic             overflow_q;
  logic             zero_q;
`endif

  assign accept = bus.in_valid && bus.in_ready;
  assign last   = (cnt == CW'(NSLICE - 1));

  // One slice of the sum per cycle; the counter selects which slice is live.
  always_comb begin : slice_add
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    a_sl    = '0;
    b_sl    = '0;
    sum_upd = sum_q;
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt == CW'(k)) begin
        a_sl = a_q[k*SLICE +: SLICE];
        b_sl = b_q[k*SLICE +: SLICE];
      end
    end
    {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt == CW'(k)) begin
        sum_upd[k*SLICE +: SLICE] = s_sl;
      end
    end
  end

  always_comb begin : fsm_next
    state_next = state;
    unique case (state)
      S_IDLE:  if (accept)        state_next = S_RUN;
      S_RUN:   if (last)          state_next = S_DONE;
      S_DONE:  if (bus.out_ready) state_next = S_IDLE;
      default:                    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : fsm_state
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: operand holding registers carry no reset; they are always loaded before being read.
  always_ff @(posedge clk) begin : operand_regs
    if (accept) begin
      a_q <= bus.a;
      b_q <= bus.subtract ? ~bus.b : bus.b;
    end
  end

  always_ff @(posedge clk) begin : datapath_regs
    if (reset) begin
      sum_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      cnt         <= '0;
`ifdef SERIAL_SLICE_ADDER_FLAGS_EN
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
`endif
    end else if (accept) begin
      carry_q <= bus.carry_in;
      cnt     <= '0;
    end else if (state == S_RUN) begin
      sum_q   <= sum_upd;
      carry_q <= c_sl;
      if (last) begin
        carry_out_q <= c_sl;
`ifdef SERIAL_SLICE_ADDER_FLAGS_EN
        // Carry into the MSB is recovered from the MSB's own sum bit.
        overflow_q  <= c_sl ^ (a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ s_sl[SLICE-1]);
        zero_q      <= (sum_upd == '0);
`endif
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (state == S_IDLE) && !reset;
  assign bus.out_valid = (state == S_DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;
`ifdef SERIAL_SLICE_ADDER_FLAGS_EN
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
`endif

`ifndef SYNTHESIS
  // A presented result must stay put until the consumer takes it.
  property p_result_hold;
    @(posedge clk) disable iff (reset)
      (bus.out_valid && !bus.out_ready) |=>
        (bus.out_valid && $stable(bus.sum) && $stable(bus.carry_out));
  endproperty
  a_result_hold: assert property (p_result_hold);

  a_no_overlap: assert property (@(posedge clk) !(bus.in_ready && bus.out_valid));
`endif

endmodule

// File: doc/serial_slice_adder.md
Name: serial_slice_adder

Overview:
Multi-cycle, parametrised successor to the ripple-carry adder chain. It adds or subtracts two WIDTH-bit operands SLICE bits per clock, LSB slice first, carrying between slices in a register. This trades latency for a short carry path. Valid/ready handshakes sit on both sides, so it drops into streaming datapaths of the toys RTL set.

Parameters:
WIDTH, 8, operand and result width in bits; must be at least 2.
SLICE, 2, bits added per cycle; must divide WIDTH exactly; SLICE == WIDTH is legal.
NSLICE (localparam), WIDTH/SLICE, number of RUN cycles per operation.

Ports:
clk  input  1  single clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high.
in_valid  input  1  operands and mode presented.
in_ready  output  1  block accepts operands this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
carry_in  input  1  carry into bit 0; for subtraction it is an inverted borrow.
subtract  input  1  0: a+b+carry_in; 1: a+~b+carry_in.
out_valid  output  1  result available.
out_ready  input  1  consumer takes the result.
sum  output  WIDTH  result.
carry_out  output  1  carry out of bit WIDTH-1.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE) && !reset. It is combinational and 0 in RUN and DONE.
- out_valid = (state==DONE). It is registered.
- Reset (at any time, including mid-RUN or in DONE):
  - next state IDLE;
  - sum = 0, carry_out = 0, slice counter = 0, internal carry = 0;
  - any in-flight operation is discarded and never emitted.
- IDLE: on in_valid && in_ready:
  - latch a;
  - latch b_eff = subtract ? ~b : b;
  - carry register = carry_in;
  - counter = 0;
  - go to RUN.
  - Without a handshake, hold; sum and carry_out keep the last result.
- RUN: each cycle, process slice k = counter, bits [k*SLICE +: SLICE]:
  - {c, s} = a_slice + b_eff_slice + carry;
  - write s into sum slice k;
  - carry = c;
  - counter++.
  - When counter == NSLICE-1, the slice is processed, carry_out = c, and the state goes to DONE.
- Arithmetic: full WIDTH+1-bit result {carry_out, sum}, modulo 2^WIDTH on sum. For a plain subtract, the caller drives carry_in = 1. carry_out = 0 then means a borrow occurred (unsigned a < b).
- Latency: handshake at edge E0, out_valid high after edge E0+NSLICE. With SLICE == WIDTH, latency is 1.
- Throughput: at most one op per NSLICE+1 cycles. DONE never accepts new operands in the same cycle.
- DONE: sum, carry_out and out_valid are held stable while out_ready = 0, with no timeout. On out_ready = 1 the state returns to IDLE next edge and out_valid drops.
- Operand inputs are ignored outside the IDLE handshake cycle; changing a or b mid-RUN has no effect.
- sum slices not yet written in RUN are don't-care to observers. Only out_valid qualifies sum.

Optional Feature:
Macro SERIAL_SLICE_ADDER_FLAGS_EN.
- Defined: adds two output ports, both registered alongside carry_out and both reset to 0.
  - overflow (1): signed overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - zero (1): high when the final sum == 0.
  - Both are valid only with out_valid and held through DONE.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, SLICE=2: a=0x5A, b=0x33, carry_in=0, subtract=0 -> out_valid exactly 4 cycles after accept, sum=0x8D, carry_out=0; flags: zero=0, overflow=1 (90+51 exceeds the signed range).
- a=0xFF, b=0x01, carry_in=0 -> sum=0x00, carry_out=1; flags: zero=1, overflow=0.
- a=0x10, b=0x20, subtract=1, carry_in=1 -> sum=0xF0, carry_out=0 (borrow); flags: overflow=0.
- Backpressure: after the first result, hold out_ready=0 for 5 cycles while in_valid=1 with new operands -> sum, carry_out and out_valid stable, in_ready=0, operands not taken. Raise out_ready -> next cycle out_valid=0 and in_ready=1. The queued operands are then accepted and the result is correct.
- Reset asserted one cycle, 2 cycles into RUN -> next cycle state IDLE, out_valid=0, sum=0x00, carry_out=0, in_ready=1; no result ever emitted for the aborted op.
- WIDTH=8, SLICE=8: a=0x7F, b=0x01 -> out_valid 1 cycle after accept, sum=0x80, carry_out=0; flags: overflow=1, zero=0.
